// File: rtl/fp64_mult_avalon_if.sv
// Avalon-MM slave bus bundle for the fp64 multiplier accelerator.
// Latency: none; this file only bundles signals.
// Backpressure: waitrequest, driven by the slave, stretches reads.
//
// Signals: address[2:0], writedata[63:0], write, read, byteenable[7:0]
//          (master -> slave); readdata[63:0], waitrequest (slave -> master).
interface fp64_mult_avalon_if;
    logic [2:0]  address;
    logic [63:0] writedata;
    logic        write;
    logic        read;
    logic [7:0]  byteenable;
    logic [63:0] readdata;
    logic        waitrequest;

    modport master (
        output address, writedata, write, read, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, writedata, write, read, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/fp64_mult_avalon.sv
// Memory-mapped IEEE-754 binary64 multiplier (truncating, flush-to-zero inputs).
// Latency: waitrequest high for MULT_LATENCY cycles, starting the cycle after a read is accepted.
// Backpressure: a read is stretched by waitrequest; writes complete in one cycle and only in IDLE.
//
// Ports: clk (rising edge), reset (synchronous, active low),
//        bus (slave modport): address 0 = A, 1 = B, others reserved for writes;
//        any read address starts A*B and returns the product on readdata.
module fp64_mult_avalon #(
    parameter int MULT_LATENCY = 4
) (
    input  logic               clk,
    input  logic               reset,
    fp64_mult_avalon_if.slave  bus
);

    localparam int CW = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [63:0] a_reg;
    logic [63:0] b_reg;

    // Writes are blocked outside IDLE, so a_reg/b_reg are stable for the
    // whole BUSY window and serve directly as the latched multiplier inputs.
    logic        sa, sb, rs;
    logic [10:0] ea, eb;
    logic [51:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [105:0] prod;
    logic signed [12:0] exp_sum;
    logic [51:0] mant;
    logic [63:0] product;
    logic        unused_lsbs;

    assign sa = a_reg[63];
    assign sb = b_reg[63];
    assign ea = a_reg[62:52];
    assign eb = b_reg[62:52];
    assign fa = a_reg[51:0];
    assign fb = b_reg[51:0];
    assign rs = sa ^ sb;

    assign a_nan  = (ea == 11'h7FF) && (fa != 52'd0);
    assign b_nan  = (eb == 11'h7FF) && (fb != 52'd0);
    assign a_inf  = (ea == 11'h7FF) && (fa == 52'd0);
    assign b_inf  = (eb == 11'h7FF) && (fb == 52'd0);
    // Denormals are flushed: exponent field 0 counts as zero.
    assign a_zero = (ea == 11'd0);
    assign b_zero = (eb == 11'd0);

    assign prod = 106'({1'b1, fa}) * 106'({1'b1, fb});

    // Product of two [1,2) significands lies in [1,4); bit 105 set means a
    // one-place normalize shift and an exponent bump.
    assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 13'sd1023
                   + (prod[105] ? 13'sd1 : 13'sd0);
    assign mant    = prod[105] ? prod[104:53] : prod[103:52];

    // Truncation discards the low product bits entirely.
    assign unused_lsbs = ^prod[51:0];

    always_comb begin
        product = {rs, exp_sum[10:0], mant};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            product = QNAN;
        end else if (a_inf || b_inf) begin
            product = {rs, 11'h7FF, 52'd0};
        end else if (a_zero || b_zero) begin
            product = {rs, 63'd0};
        end else if (exp_sum >= 13'sd2047) begin
            product = {rs, 11'h7FF, 52'd0};
        end else if (exp_sum <= 13'sd0) begin
            product = {rs, 63'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            bus.readdata    <= '0;
            bus.waitrequest <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A simultaneous read and write performs only the write.
                    if (bus.write) begin
                        for (int i = 0; i < 8; i++) begin
                            if (bus.byteenable[i]) begin
                                if (bus.address == 3'd0)
                                    a_reg[8*i +: 8] <= bus.writedata[8*i +: 8];
                                else if (bus.address == 3'd1)
                                    b_reg[8*i +: 8] <= bus.writedata[8*i +: 8];
                            end
                        end
                    end else if (bus.read) begin
                        state           <= BUSY;
                        cnt             <= '0;
                        bus.waitrequest <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == CW'(MULT_LATENCY - 1)) begin
                        bus.readdata    <= product;
                        bus.waitrequest <= 1'b0;
                        state           <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    // Holding read here must not start another multiply.
                    if (!bus.read)
                        state <= IDLE;
                end
                default: begin
                    state           <= IDLE;
                    bus.waitrequest <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp64_mult_avalon.sv
// Directed bench for fp64_mult_avalon: operand writes, multiplies, special cases, reset abort.
// Latency: expects waitrequest high for exactly MULT_LATENCY cycles per read.
// Backpressure: every wait on waitrequest is bounded by a cycle budget.
module tb_fp64_mult_avalon;

    localparam int LAT = 4;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    fp64_mult_avalon_if bus_if ();

    fp64_mult_avalon #(.MULT_LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [63:0] data, input logic [7:0] be);
        bus_if.address    = addr;
        bus_if.writedata  = data;
        bus_if.byteenable = be;
        bus_if.write      = 1'b1;
        tick();
        bus_if.write      = 1'b0;
        bus_if.byteenable = 8'h00;
    endtask

    // Two half-writes; the disabled half carries junk that must not land.
    task automatic write_split(input logic [2:0] addr, input logic [63:0] v);
        bus_write(addr, {32'hDEAD_BEEF, v[31:0]}, 8'h0F);
        bus_write(addr, {v[63:32], 32'h1234_5678}, 8'hF0);
    endtask

    // Count waitrequest-high cycles after the accept edge, bounded.
    task automatic wait_done(output int n);
        n = 1;
        while (bus_if.waitrequest === 1'b1 && n < 100) begin
            tick();
            if (bus_if.waitrequest === 1'b1) n++;
        end
    endtask

    task automatic do_read(input logic [2:0] addr, input logic [63:0] exp, input string tag, input bit hold);
        int n;
        bus_if.address = addr;
        bus_if.read    = 1'b1;
        check({tag, "_wr_before"}, {63'd0, bus_if.waitrequest}, 64'd0);
        tick();
        check({tag, "_wr_rise"}, {63'd0, bus_if.waitrequest}, 64'd1);
        wait_done(n);
        check({tag, "_wr_cycles"}, 64'(n), 64'(LAT));
        check({tag, "_readdata"}, bus_if.readdata, exp);
        if (hold) begin
            tick();
            check({tag, "_hold_no_retrigger"}, {63'd0, bus_if.waitrequest}, 64'd0);
            bus_if.read = 1'b0;
            tick();
            check({tag, "_hold_exit"}, {63'd0, bus_if.waitrequest}, 64'd0);
            check({tag, "_hold_data"}, bus_if.readdata, exp);
        end else begin
            bus_if.read = 1'b0;
            tick();
        end
    endtask

    task automatic mul_test(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                            input string tag, input bit hold);
        write_split(3'd0, a);
        write_split(3'd1, b);
        do_read(3'd0, exp, tag, hold);
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        bus_if.address    = 3'd0;
        bus_if.writedata  = 64'd0;
        bus_if.write      = 1'b0;
        bus_if.read       = 1'b0;
        bus_if.byteenable = 8'h00;
        repeat (3) tick();
        check("reset_wr", {63'd0, bus_if.waitrequest}, 64'd0);
        check("reset_rd", bus_if.readdata, 64'd0);
        reset = 1'b1;
        tick();

        mul_test(64'h40092AF77DB8CC83, 64'h4018F0329122D34E, 64'h40339D23A3C24D1A, "basic", 1'b0);
        mul_test(64'hC035A77C30B4E545, 64'h40846EF84C02BC6E, 64'hC0CBA78ABD952F0E, "neg_pos", 1'b0);
        mul_test(64'hC0C3330E104E9E8A, 64'hBFEBF762613CAAF7, 64'h40C0C780F9026F7C, "neg_neg", 1'b0);
        mul_test(64'h405305F0F163539F, 64'hC0C376AFB269A3EF, 64'hC127242AD4B53267, "mixed", 1'b1);

        // Reserved-address write ignored; read address is irrelevant.
        bus_write(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        do_read(3'd5, 64'hC127242AD4B53267, "reserved_wr", 1'b0);

        // Write during BUSY is dropped: product still uses the old A.
        bus_if.address = 3'd0;
        bus_if.read    = 1'b1;
        tick();
        bus_if.writedata  = 64'h3FF0_0000_0000_0000;
        bus_if.byteenable = 8'hFF;
        bus_if.write      = 1'b1;
        tick();
        bus_if.write      = 1'b0;
        bus_if.byteenable = 8'h00;
        wait_done(n);
        check("busy_wr_cycles", 64'(n), 64'(LAT - 1));
        check("busy_wr_data", bus_if.readdata, 64'hC127242AD4B53267);
        bus_if.read = 1'b0;
        tick();
        do_read(3'd0, 64'hC127242AD4B53267, "busy_wr_after", 1'b0);

        mul_test(64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000, "inf_x_zero", 1'b0);
        mul_test(64'h3FF0000000000000, 64'h8000000000000000, 64'h8000000000000000, "one_x_negzero", 1'b0);
        mul_test(64'h7FE0000000000000, 64'h7FE0000000000000, 64'h7FF0000000000000, "overflow", 1'b0);

        // Reset asserted mid-BUSY aborts the multiply and clears everything.
        mul_test(64'h40092AF77DB8CC83, 64'h4018F0329122D34E, 64'h40339D23A3C24D1A, "pre_abort", 1'b0);
        bus_if.read = 1'b1;
        tick();
        tick();
        check("abort_busy", {63'd0, bus_if.waitrequest}, 64'd1);
        reset       = 1'b0;
        bus_if.read = 1'b0;
        tick();
        check("abort_wr", {63'd0, bus_if.waitrequest}, 64'd0);
        check("abort_rd", bus_if.readdata, 64'd0);
        reset = 1'b1;
        tick();
        do_read(3'd3, 64'd0, "post_reset", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp64_mult_avalon.md
Name: fp64_mult_avalon

Overview:
- Avalon-MM slave wrapping an IEEE-754 double-precision floating-point multiplier.
- Software writes operands A and B over a 64-bit bus with byte enables.
- A read starts the multiply. waitrequest stretches the read until the product is returned on readdata.
- Sits on the processor/system interconnect as a memory-mapped accelerator.

Parameters:
- MULT_LATENCY, 4: number of clock cycles waitrequest is held high per read (minimum 1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- address  in  3  word address: 0 = operand A, 1 = operand B, 2..7 reserved.
- writedata  in  64  write data.
- write  in  1  write strobe.
- read  in  1  read strobe; starts a multiply.
- byteenable  in  8  per-byte write lane enables; bit i enables writedata[8i+7:8i].
- readdata  out  64  product A*B (IEEE-754 binary64).
- waitrequest  out  1  high while the multiply is in progress.

Behaviour:
- Reset (reset==0 at a rising edge):
  - A, B, readdata cleared to 0; waitrequest = 0.
  - FSM goes to IDLE; any in-flight multiply is aborted.
- Writes (IDLE only):
  - write=1 at address 0 updates the A bytes whose byteenable bit is set; address 1 does the same for B.
  - Other addresses are ignored. Unenabled bytes are retained.
  - Writes in BUSY or DONE are ignored.
- FSM:
  - IDLE:
    - read=1 and write=0 → latch A,B into the multiplier, go to BUSY, waitrequest=1 from the next cycle.
    - read and write together → write is performed, read ignored.
    - Read is accepted at any address; the result is always the product.
  - BUSY:
    - waitrequest=1 for exactly MULT_LATENCY cycles.
    - On the final cycle, register the product into readdata, drop waitrequest, go to DONE.
  - DONE:
    - waitrequest=0; readdata holds the product.
    - Stays in DONE while read=1, so a read held past completion does not retrigger.
    - read=0 → IDLE.
- readdata retains the last product until the next completion or reset.
- Arithmetic:
  - sign = signA XOR signB.
  - Exponent = eA + eB − 1023.
  - Mantissa: 53×53-bit product of significands with hidden 1; normalize by 1 if bit 105 is set.
  - Rounding: truncate (round toward zero), no rounding increment.
- Special cases:
  - Either operand NaN, or Inf×0 → 0x7FF8000000000000.
  - Inf × nonzero → signed Inf.
  - Either operand zero or denormal (exponent field 0) → signed zero (flush-to-zero inputs).
  - Biased result exponent ≥ 2047 → signed Inf.
  - Biased result exponent ≤ 0 → signed zero.
- Operand registers are untouched by reads.
- Reset asserted mid-BUSY: waitrequest drops, FSM goes to IDLE, and readdata clears at that edge.

Test Plan:
- Basic multiply: A=0x40092AF77DB8CC83 written as two half-writes (byteenable 0x0F then 0xF0), B=0x4018F0329122D34E likewise, then read held until waitrequest falls.
  - Required: waitrequest rises one cycle after read and stays high MULT_LATENCY cycles.
  - Required: readdata=0x40339D23A3C24D1A.
- Negative × positive: A=0xC035A77C30B4E545, B=0x40846EF84C02BC6E → readdata=0xC0CBA78ABD952F0E.
- Negative × negative: A=0xC0C3330E104E9E8A, B=0xBFEBF762613CAAF7 → readdata=0x40C0C780F9026F7C.
- Mixed sign: A=0x405305F0F163539F, B=0xC0C376AFB269A3EF → readdata=0xC127242AD4B53267.
  - Then hold read one cycle after waitrequest falls: FSM stays in DONE, no second waitrequest pulse.
- Special operands:
  - A=0x7FF0000000000000 × B=0 → 0x7FF8000000000000.
  - A=0x3FF0000000000000 × B=0x8000000000000000 → 0x8000000000000000.
  - A=B=0x7FE0000000000000 → 0x7FF0000000000000.
- Write during BUSY ignored; reset=0 mid-BUSY → waitrequest=0, readdata=0 next cycle.
  - A subsequent read returns the product of the pre-reset operands only if they were rewritten; after reset A=B=0, so result is 0.
